// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 protocol monitor: channel stability, burst-length tracking, outstanding accounting,
// handshake timeouts and sticky error flags with a maskable registered interrupt.
module axi4_protocol_monitor #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT         = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic                            S_AXI_AWVALID,
    input  logic                            S_AXI_AWREADY,
    input  logic [ID_WIDTH-1:0]             S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_WVALID,
    input  logic                            S_AXI_WREADY,
    input  logic [DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]             S_AXI_BID,
    input  logic [1:0]                      S_AXI_BRESP,
    input  logic                            S_AXI_ARVALID,
    input  logic                            S_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]             S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [ID_WIDTH-1:0]             S_AXI_RID,
    input  logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
    input  logic [1:0]                      S_AXI_RRESP,
    input  logic                            S_AXI_RLAST,
    input  logic                            err_clr,
    input  logic [14:0]                     err_mask,
    output logic [14:0]                     err_flags,
    output logic [3:0]                      first_err,
    output logic                            err_irq,
    output logic [$clog2(MAX_OUTSTANDING):0] aw_pending,
    output logic [$clog2(MAX_OUTSTANDING):0] ar_pending
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int AXP_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 3;
    localparam int WP_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int BP_W  = ID_WIDTH + 2;
    localparam int RP_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [AXP_W-1:0] w_awPay, w_arPay, r_awPrevPay, r_arPrevPay;
    logic [WP_W-1:0]  w_wPay, r_wPrevPay;
    logic [BP_W-1:0]  w_bPay, r_bPrevPay;
    logic [RP_W-1:0]  w_rPay, r_rPrevPay;
    logic             r_awPrevValid, r_awPrevReady, r_wPrevValid, r_wPrevReady;
    logic             r_bPrevValid, r_bPrevReady, r_arPrevValid, r_arPrevReady;
    logic             r_rPrevValid, r_rPrevReady;
    logic             w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;

    assign w_awPay = {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWPROT};
    assign w_arPay = {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARPROT};
    assign w_wPay  = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
    assign w_bPay  = {S_AXI_BID, S_AXI_BRESP};
    assign w_rPay  = {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};

    assign w_awHs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_wHs  = S_AXI_WVALID & S_AXI_WREADY;
    assign w_bHs  = S_AXI_BVALID & S_AXI_BREADY;
    assign w_arHs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_rHs  = S_AXI_RVALID & S_AXI_RREADY;

    // Previous-cycle view of every channel; VALID history resets low so nothing fires right after reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_awPrevValid <= 1'b0;
            r_awPrevReady <= 1'b0;
            r_awPrevPay   <= '0;
            r_wPrevValid  <= 1'b0;
            r_wPrevReady  <= 1'b0;
            r_wPrevPay    <= '0;
            r_bPrevValid  <= 1'b0;
            r_bPrevReady  <= 1'b0;
            r_bPrevPay    <= '0;
            r_arPrevValid <= 1'b0;
            r_arPrevReady <= 1'b0;
            r_arPrevPay   <= '0;
            r_rPrevValid  <= 1'b0;
            r_rPrevReady  <= 1'b0;
            r_rPrevPay    <= '0;
        end else begin
            r_awPrevValid <= S_AXI_AWVALID;
            r_awPrevReady <= S_AXI_AWREADY;
            r_awPrevPay   <= w_awPay;
            r_wPrevValid  <= S_AXI_WVALID;
            r_wPrevReady  <= S_AXI_WREADY;
            r_wPrevPay    <= w_wPay;
            r_bPrevValid  <= S_AXI_BVALID;
            r_bPrevReady  <= S_AXI_BREADY;
            r_bPrevPay    <= w_bPay;
            r_arPrevValid <= S_AXI_ARVALID;
            r_arPrevReady <= S_AXI_ARREADY;
            r_arPrevPay   <= w_arPay;
            r_rPrevValid  <= S_AXI_RVALID;
            r_rPrevReady  <= S_AXI_RREADY;
            r_rPrevPay    <= w_rPay;
        end
    end

    logic w_awWait, w_wWait, w_bWait, w_arWait, w_rWait;
    assign w_awWait = r_awPrevValid & ~r_awPrevReady;
    assign w_wWait  = r_wPrevValid & ~r_wPrevReady;
    assign w_bWait  = r_bPrevValid & ~r_bPrevReady;
    assign w_arWait = r_arPrevValid & ~r_arPrevReady;
    assign w_rWait  = r_rPrevValid & ~r_rPrevReady;

    // Write-length FIFO plus the count of bursts whose data is done but whose B is still owed.
    logic [7:0]       r_wrMem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wrHead, r_wrTail;
    logic [CNT_W-1:0] r_wrCount, r_wrDone;
    logic [7:0]       r_wBeat;
    logic             w_wrEmpty, w_wrFull, w_wLastExp, w_wPop, w_wLastErr;
    logic             w_bDec, w_bUnexp, w_awOvf, w_awPush;

    assign w_wrEmpty  = (r_wrCount == '0);
    assign w_wrFull   = (r_wrCount == MAX_CNT);
    assign w_wLastExp = (r_wBeat == r_wrMem[r_wrHead]);
    assign w_wPop     = w_wHs & ~w_wrEmpty & w_wLastExp;
    assign w_wLastErr = w_wHs & (w_wrEmpty | (S_AXI_WLAST != w_wLastExp));
    assign w_bDec     = w_bHs & (r_wrDone != '0);
    assign w_bUnexp   = w_bHs & (r_wrDone == '0);
    assign w_awOvf    = w_awHs & ((w_wrFull & ~w_wPop) | ((aw_pending == MAX_CNT) & ~w_bDec));
    assign w_awPush   = w_awHs & ~w_awOvf;
    assign aw_pending = r_wrCount + r_wrDone;

    // Read-length FIFO; read bursts complete on RLAST so no separate response counter.
    logic [7:0]       r_rdMem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_rdHead, r_rdTail;
    logic [CNT_W-1:0] r_rdCount;
    logic [7:0]       r_rBeat;
    logic             w_rdEmpty, w_rdFull, w_rLastExp, w_rPop, w_rLastErr;
    logic             w_rUnexp, w_arOvf, w_arPush;

    assign w_rdEmpty  = (r_rdCount == '0);
    assign w_rdFull   = (r_rdCount == MAX_CNT);
    assign w_rLastExp = (r_rBeat == r_rdMem[r_rdHead]);
    assign w_rPop     = w_rHs & ~w_rdEmpty & w_rLastExp;
    assign w_rLastErr = w_rHs & ~w_rdEmpty & (S_AXI_RLAST != w_rLastExp);
    assign w_rUnexp   = w_rHs & w_rdEmpty;
    assign w_arOvf    = w_arHs & w_rdFull & ~w_rPop;
    assign w_arPush   = w_arHs & ~w_arOvf;
    assign ar_pending = r_rdCount;

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_awPush) begin
            r_wrMem[r_wrTail] <= S_AXI_AWLEN;
        end
        if (w_arPush) begin
            r_rdMem[r_rdTail] <= S_AXI_ARLEN;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wrHead  <= '0;
            r_wrTail  <= '0;
            r_wrCount <= '0;
            r_wrDone  <= '0;
            r_wBeat   <= '0;
            r_rdHead  <= '0;
            r_rdTail  <= '0;
            r_rdCount <= '0;
            r_rBeat   <= '0;
        end else begin
            if (w_awPush) begin
                r_wrTail <= r_wrTail + 1'b1;
            end
            if (w_wPop) begin
                r_wrHead <= r_wrHead + 1'b1;
            end
            r_wrCount <= r_wrCount + CNT_W'(w_awPush) - CNT_W'(w_wPop);
            r_wrDone  <= r_wrDone + CNT_W'(w_wPop) - CNT_W'(w_bDec);
            if (w_wHs && !w_wrEmpty) begin
                r_wBeat <= w_wPop ? 8'd0 : r_wBeat + 8'd1;
            end
            if (w_arPush) begin
                r_rdTail <= r_rdTail + 1'b1;
            end
            if (w_rPop) begin
                r_rdHead <= r_rdHead + 1'b1;
            end
            r_rdCount <= r_rdCount + CNT_W'(w_arPush) - CNT_W'(w_rPop);
            if (w_rHs && !w_rdEmpty) begin
                r_rBeat <= w_rPop ? 8'd0 : r_rBeat + 8'd1;
            end
        end
    end

    // Stall counters saturate at TIMEOUT so each stall episode raises the flag only once.
    logic [4:0]      w_stall, w_toHit;
    logic [TO_W-1:0] r_toCnt [5];

    assign w_stall = {S_AXI_RVALID & ~S_AXI_RREADY, S_AXI_ARVALID & ~S_AXI_ARREADY,
                      S_AXI_BVALID & ~S_AXI_BREADY, S_AXI_WVALID & ~S_AXI_WREADY,
                      S_AXI_AWVALID & ~S_AXI_AWREADY};

    always_comb begin
        w_toHit = '0;
        for (int i = 0; i < 5; i++) begin
            w_toHit[i] = w_stall[i] & (r_toCnt[i] == TO_W'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 5; i++) begin
                r_toCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!w_stall[i]) begin
                    r_toCnt[i] <= '0;
                end else if (r_toCnt[i] != TO_W'(TIMEOUT)) begin
                    r_toCnt[i] <= r_toCnt[i] + 1'b1;
                end
            end
        end
    end

    logic [14:0] w_viol;
    assign w_viol[0]  = w_awWait & ~S_AXI_AWVALID;
    assign w_viol[1]  = w_awWait & S_AXI_AWVALID & (w_awPay != r_awPrevPay);
    assign w_viol[2]  = w_wWait & ~S_AXI_WVALID;
    assign w_viol[3]  = w_wWait & S_AXI_WVALID & (w_wPay != r_wPrevPay);
    assign w_viol[4]  = w_arWait & ~S_AXI_ARVALID;
    assign w_viol[5]  = w_arWait & S_AXI_ARVALID & (w_arPay != r_arPrevPay);
    assign w_viol[6]  = w_rWait & ~S_AXI_RVALID;
    assign w_viol[7]  = w_rWait & S_AXI_RVALID & (w_rPay != r_rPrevPay);
    assign w_viol[8]  = w_bWait & (~S_AXI_BVALID | (w_bPay != r_bPrevPay));
    assign w_viol[9]  = w_wLastErr;
    assign w_viol[10] = w_rLastErr;
    assign w_viol[11] = w_bUnexp;
    assign w_viol[12] = w_rUnexp;
    assign w_viol[13] = w_awOvf | w_arOvf;
    assign w_viol[14] = |w_toHit;

    function automatic logic [3:0] lowestSet(input logic [14:0] v);
        lowestSet = 4'hF;
        for (int i = 14; i >= 0; i--) begin
            if (v[i]) begin
                lowestSet = 4'(i);
            end
        end
    endfunction

    logic [14:0] r_errFlags, w_flagsBase, w_newBits, w_flagsNext;
    logic [3:0]  r_firstErr, w_firstNext;
    logic        r_errIrq;

    // A clear and a violation on the same edge: the violation survives and re-seeds first_err.
    always_comb begin
        w_flagsBase = err_clr ? 15'd0 : r_errFlags;
        w_newBits   = w_viol & ~w_flagsBase;
        w_flagsNext = w_flagsBase | w_viol;
        w_firstNext = err_clr ? 4'hF : r_firstErr;
        if ((err_clr || r_firstErr == 4'hF) && w_newBits != 15'd0) begin
            w_firstNext = lowestSet(w_newBits);
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_errFlags <= '0;
            r_firstErr <= 4'hF;
            r_errIrq   <= 1'b0;
        end else begin
            r_errFlags <= w_flagsNext;
            r_firstErr <= w_firstNext;
            r_errIrq   <= |(r_errFlags & err_mask);
        end
    end

    assign err_flags = r_errFlags;
    assign first_err = r_firstErr;
    assign err_irq   = r_errIrq;

endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Directed testbench for axi4_protocol_monitor with hand-computed expected values.
module tb_axi4_protocol_monitor;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        awValid, awReady, wValid, wReady, wLast, bValid, bReady;
    logic        arValid, arReady, rValid, rReady, rLast;
    logic [3:0]  awId, bId, arId, rId;
    logic [31:0] awAddr, arAddr, wData, rData;
    logic [7:0]  awLen, arLen;
    logic [2:0]  awSize, arSize, awProt, arProt;
    logic [1:0]  awBurst, arBurst, bResp, rResp;
    logic [3:0]  wStrb;
    logic        errClr;
    logic [14:0] errMask;
    logic [14:0] errFlags;
    logic [3:0]  firstErr;
    logic        errIrq;
    logic [3:0]  awPending, arPending;

    int checkCount = 0;
    int errorCount = 0;

    axi4_protocol_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .S_AXI_ACLK(clock), .S_AXI_ARESET(reset),
        .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady), .S_AXI_AWID(awId), .S_AXI_AWADDR(awAddr),
        .S_AXI_AWLEN(awLen), .S_AXI_AWSIZE(awSize), .S_AXI_AWBURST(awBurst), .S_AXI_AWPROT(awProt),
        .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady), .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb),
        .S_AXI_WLAST(wLast),
        .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady), .S_AXI_BID(bId), .S_AXI_BRESP(bResp),
        .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady), .S_AXI_ARID(arId), .S_AXI_ARADDR(arAddr),
        .S_AXI_ARLEN(arLen), .S_AXI_ARSIZE(arSize), .S_AXI_ARBURST(arBurst), .S_AXI_ARPROT(arProt),
        .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady), .S_AXI_RID(rId), .S_AXI_RDATA(rData),
        .S_AXI_RRESP(rResp), .S_AXI_RLAST(rLast),
        .err_clr(errClr), .err_mask(errMask), .err_flags(errFlags), .first_err(firstErr),
        .err_irq(errIrq), .aw_pending(awPending), .ar_pending(arPending)
    );

    always #5 clock = ~clock;

    // Advance the given number of rising edges and settle just after the last one.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {awValid, awReady, wValid, wReady, wLast, bValid, bReady} = '0;
        {arValid, arReady, rValid, rReady, rLast} = '0;
        {awId, bId, arId, rId} = '0;
        {awAddr, arAddr, wData, rData} = '0;
        {awLen, arLen, awSize, arSize, awProt, arProt} = '0;
        {awBurst, arBurst, bResp, rResp} = '0;
        wStrb   = 4'hF;
        errClr  = 1'b0;
        errMask = 15'h0020;
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("reset_flags", 32'(errFlags), 32'h0);
        checkOutput("reset_first", 32'(firstErr), 32'hF);
        checkOutput("reset_irq", 32'(errIrq), 32'h0);
        checkOutput("reset_awpend", 32'(awPending), 32'h0);
        checkOutput("reset_arpend", 32'(arPending), 32'h0);

        // Clean 4-beat write burst.
        awValid = 1'b1; awReady = 1'b1; awLen = 8'd3; awId = 4'd2; awAddr = 32'h1000;
        applyStimulus(1);
        awValid = 1'b0; awReady = 1'b0;
        checkOutput("wr_awpend_after_aw", 32'(awPending), 32'h1);
        wValid = 1'b1; wReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wData = 32'(i); wLast = (i == 3);
            applyStimulus(1);
        end
        wValid = 1'b0; wReady = 1'b0; wLast = 1'b0;
        checkOutput("wr_awpend_before_b", 32'(awPending), 32'h1);
        bValid = 1'b1; bReady = 1'b1; bId = 4'd2;
        applyStimulus(1);
        bValid = 1'b0; bReady = 1'b0;
        checkOutput("wr_awpend_after_b", 32'(awPending), 32'h0);
        checkOutput("wr_flags_clean", 32'(errFlags), 32'h0);

        // AR payload change while stalled.
        arValid = 1'b1; arReady = 1'b0; arAddr = 32'h100; arLen = 8'd0;
        applyStimulus(2);
        arAddr = 32'h104;
        applyStimulus(1);
        checkOutput("ar_payload_flag", 32'(errFlags), 32'h0020);
        checkOutput("ar_payload_first", 32'(firstErr), 32'h5);
        checkOutput("ar_irq_not_yet", 32'(errIrq), 32'h0);
        arReady = 1'b1;
        applyStimulus(1);
        arValid = 1'b0; arReady = 1'b0;
        checkOutput("ar_irq_set", 32'(errIrq), 32'h1);
        checkOutput("ar_pend_one", 32'(arPending), 32'h1);
        rValid = 1'b1; rReady = 1'b1; rLast = 1'b1;
        applyStimulus(1);
        rValid = 1'b0; rReady = 1'b0; rLast = 1'b0;
        checkOutput("ar_pend_drained", 32'(arPending), 32'h0);
        errMask = 15'h7FFF;
        errClr = 1'b1;
        applyStimulus(1);
        errClr = 1'b0;
        checkOutput("clr_flags", 32'(errFlags), 32'h0);
        checkOutput("clr_first", 32'(firstErr), 32'hF);
        applyStimulus(1);
        checkOutput("clr_irq", 32'(errIrq), 32'h0);

        // Early WLAST, then R beat with nothing outstanding.
        awValid = 1'b1; awReady = 1'b1; awLen = 8'd1;
        applyStimulus(1);
        awValid = 1'b0; awReady = 1'b0;
        wValid = 1'b1; wReady = 1'b1; wLast = 1'b1;
        applyStimulus(2);
        wValid = 1'b0; wReady = 1'b0; wLast = 1'b0;
        checkOutput("wlast_flag", 32'(errFlags), 32'h0200);
        checkOutput("wlast_first", 32'(firstErr), 32'h9);
        rValid = 1'b1; rReady = 1'b1; rLast = 1'b1;
        applyStimulus(1);
        rValid = 1'b0; rReady = 1'b0; rLast = 1'b0;
        checkOutput("unexp_r_flags", 32'(errFlags), 32'h1200);
        checkOutput("unexp_r_first", 32'(firstErr), 32'h9);
        bValid = 1'b1; bReady = 1'b1;
        applyStimulus(1);
        bValid = 1'b0; bReady = 1'b0;
        checkOutput("wlast_awpend_drained", 32'(awPending), 32'h0);
        errClr = 1'b1;
        applyStimulus(1);
        errClr = 1'b0;

        // Nine AR handshakes against an eight-deep read FIFO.
        arValid = 1'b1; arReady = 1'b1; arLen = 8'd0;
        applyStimulus(8);
        checkOutput("ovf_pend_eight", 32'(arPending), 32'h8);
        checkOutput("ovf_no_flag_yet", 32'(errFlags), 32'h0);
        applyStimulus(1);
        arValid = 1'b0; arReady = 1'b0;
        checkOutput("ovf_flag", 32'(errFlags), 32'h2000);
        checkOutput("ovf_first", 32'(firstErr), 32'hD);
        checkOutput("ovf_pend_held", 32'(arPending), 32'h8);
        rValid = 1'b1; rReady = 1'b1; rLast = 1'b1;
        applyStimulus(8);
        rValid = 1'b0; rReady = 1'b0; rLast = 1'b0;
        checkOutput("ovf_drained", 32'(arPending), 32'h0);
        checkOutput("ovf_drain_clean", 32'(errFlags), 32'h2000);
        errClr = 1'b1;
        applyStimulus(1);
        errClr = 1'b0;

        // W stall timeout boundary.
        wValid = 1'b1; wReady = 1'b0;
        applyStimulus(TIMEOUT - 1);
        checkOutput("to_not_early", 32'(errFlags), 32'h0);
        applyStimulus(1);
        checkOutput("to_flag", 32'(errFlags), 32'h4000);
        checkOutput("to_first", 32'(firstErr), 32'hE);

        // Clear coinciding with a W drop, then with an unexpected B.
        wValid = 1'b0; errClr = 1'b1;
        applyStimulus(1);
        checkOutput("clr_drop_flags", 32'(errFlags), 32'h0004);
        checkOutput("clr_drop_first", 32'(firstErr), 32'h2);
        bValid = 1'b1; bReady = 1'b1;
        applyStimulus(1);
        bValid = 1'b0; bReady = 1'b0; errClr = 1'b0;
        checkOutput("clr_b_flags", 32'(errFlags), 32'h0800);
        checkOutput("clr_b_first", 32'(firstErr), 32'hB);
        checkOutput("clr_b_awpend", 32'(awPending), 32'h0);

        // Reset in the middle of a read burst.
        arValid = 1'b1; arReady = 1'b1; arLen = 8'd3;
        applyStimulus(1);
        arValid = 1'b0; arReady = 1'b0;
        rValid = 1'b1; rReady = 1'b1; rLast = 1'b0;
        applyStimulus(2);
        checkOutput("mid_irq_before", 32'(errIrq), 32'h1);
        checkOutput("mid_pend_before", 32'(arPending), 32'h1);
        reset = 1'b1;
        #2;
        checkOutput("mid_rst_flags", 32'(errFlags), 32'h0);
        checkOutput("mid_rst_first", 32'(firstErr), 32'hF);
        checkOutput("mid_rst_irq", 32'(errIrq), 32'h0);
        checkOutput("mid_rst_arpend", 32'(arPending), 32'h0);
        rValid = 1'b0; rReady = 1'b0;
        applyStimulus(1);
        reset = 1'b0;
        arValid = 1'b1; arReady = 1'b1; arLen = 8'd0;
        applyStimulus(1);
        arValid = 1'b0; arReady = 1'b0;
        rValid = 1'b1; rReady = 1'b1; rLast = 1'b1;
        applyStimulus(1);
        rValid = 1'b0; rReady = 1'b0; rLast = 1'b0;
        checkOutput("post_rst_flags", 32'(errFlags), 32'h0);
        checkOutput("post_rst_arpend", 32'(arPending), 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
